// File: rtl/vu_level_tracker_if.sv
// rtl/vu_level_tracker_if.sv - sample input and meter output bundle for the VU level tracker
interface vu_level_tracker_if;
   logic       enable;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic [7:0] level;
   logic [7:0] peak;
   logic       clip;
   logic       update;

   // Upstream side: drives samples and enable, observes meter quantities
   modport master (
      output enable, sample_in, sample_valid,
      input  level, peak, clip, update
   );

   // Tracker side
   modport slave (
      input  enable, sample_in, sample_valid,
      output level, peak, clip, update
   );
endinterface

// File: rtl/vu_level_tracker.sv
// rtl/vu_level_tracker.sv - VU meter level with instant attack, linear release, peak hold and clip flag
module vu_level_tracker #(
   parameter int DECAY_DIV  = 100000,
   parameter int HOLD_TICKS = 50,
   parameter int REL_STEP   = 1,
   parameter int PEAK_STEP  = 2,
   parameter int CLIP_LEVEL = 240
) (
   input  logic                i_clock,
   input  logic                i_reset,
   vu_level_tracker_if.slave   i_bus
);

   localparam int PW = $clog2(DECAY_DIV);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DECAY_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS);
   localparam logic [7:0]    REL        = 8'(REL_STEP);
   localparam logic [7:0]    PSTEP      = 8'(PEAK_STEP);
   localparam logic [8:0]    CLIP_THR   = 9'(CLIP_LEVEL);

   typedef enum logic [1:0] {ST_TRACK, ST_HOLD, ST_FALL} state_t;

   state_t        r_state;
   logic [PW-1:0] r_presc;
   logic [HW-1:0] r_hold_cnt;
   logic [HW-1:0] r_clip_cnt;
   logic [7:0]    r_level;
   logic [7:0]    r_peak;
   logic          r_clip;
   logic          r_update;

   logic [7:0]    w_mag;
   logic          w_tick;
   logic [7:0]    w_decayed;
   logic [7:0]    w_next_level;
   logic [7:0]    w_fall_peak;
   logic [7:0]    w_next_peak;
   logic [HW-1:0] w_next_hold;
   state_t        w_next_state;
   logic [HW-1:0] w_next_clip_cnt;
   logic          w_next_clip;
   logic          w_next_update;

   // Magnitude of the offset-binary sample, release decay and the attack comparison
   always_comb begin
      w_mag = i_bus.sample_in[7] ? {i_bus.sample_in[6:0], 1'b0}
                                 : {~i_bus.sample_in[6:0], 1'b0};
      w_tick = i_bus.enable && (r_presc == PRESC_LAST);
      w_decayed = r_level;
      if (w_tick) begin
         w_decayed = (r_level >= REL) ? (r_level - REL) : 8'd0;
      end
      w_next_level = w_decayed;
      if (i_bus.sample_valid && (w_mag > w_decayed)) begin
         w_next_level = w_mag;
      end
   end

   // Peak-hold FSM: a new high re-arms the hold, otherwise track, hold or fall
   always_comb begin
      w_next_peak  = r_peak;
      w_next_hold  = r_hold_cnt;
      w_next_state = r_state;
      w_fall_peak  = (r_peak >= PSTEP) ? (r_peak - PSTEP) : 8'd0;
      if (w_next_level > r_peak) begin
         w_next_peak  = w_next_level;
         w_next_hold  = '0;
         w_next_state = ST_HOLD;
      end else begin
         case (r_state)
            ST_TRACK: begin
               w_next_peak = w_next_level;
            end
            ST_HOLD: begin
               if (w_tick) begin
                  if (r_hold_cnt == HOLD_LAST) begin
                     w_next_state = ST_FALL;
                     w_next_hold  = '0;
                  end else begin
                     w_next_hold = r_hold_cnt + HW'(1);
                  end
               end
            end
            ST_FALL: begin
               if (w_tick) begin
                  if (w_fall_peak <= w_next_level) begin
                     w_next_peak  = w_next_level;
                     w_next_state = ST_TRACK;
                  end else begin
                     w_next_peak = w_fall_peak;
                  end
               end
            end
            default: begin
               w_next_state = ST_TRACK;
            end
         endcase
      end
   end

   // Clip hold counter: a loud sample reloads it, ticks drain it; update flags any visible change
   always_comb begin
      w_next_clip_cnt = r_clip_cnt;
      if (i_bus.sample_valid && ({1'b0, w_mag} >= CLIP_THR)) begin
         w_next_clip_cnt = HOLD_LOAD;
      end else if (w_tick && (r_clip_cnt != '0)) begin
         w_next_clip_cnt = r_clip_cnt - HW'(1);
      end
      w_next_clip   = (w_next_clip_cnt != '0);
      w_next_update = (w_next_level != r_level) || (w_next_peak != r_peak) ||
                      (w_next_clip != r_clip);
   end

   // State registers; disabled cycles hold everything, including the update pulse
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= ST_TRACK;
         r_presc    <= '0;
         r_hold_cnt <= '0;
         r_clip_cnt <= '0;
         r_level    <= 8'd0;
         r_peak     <= 8'd0;
         r_clip     <= 1'b0;
         r_update   <= 1'b0;
      end else if (i_bus.enable) begin
         r_presc    <= w_tick ? '0 : (r_presc + PW'(1));
         r_state    <= w_next_state;
         r_hold_cnt <= w_next_hold;
         r_clip_cnt <= w_next_clip_cnt;
         r_level    <= w_next_level;
         r_peak     <= w_next_peak;
         r_clip     <= w_next_clip;
         r_update   <= w_next_update;
      end
   end

   assign i_bus.level  = r_level;
   assign i_bus.peak   = r_peak;
   assign i_bus.clip   = r_clip;
   assign i_bus.update = r_update;

endmodule

// File: tb/tb_vu_level_tracker.sv
// tb/tb_vu_level_tracker.sv - scoreboard bench for vu_level_tracker against a behavioural meter model
module tb_vu_level_tracker;
   localparam int DIV   = 4;
   localparam int HOLD  = 3;
   localparam int REL   = 1;
   localparam int PSTEP = 2;
   localparam int CLIPL = 240;
   localparam int M_TRACK = 0;
   localparam int M_HOLD  = 1;
   localparam int M_FALL  = 2;

   typedef struct {
      int level;
      int peak;
      bit clip;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   bit   started = 1'b0;
   exp_t sb_q[$];
   exp_t e;

   int m_level, m_peak, m_presc, m_mode, m_hold_left, m_clip_left;
   bit m_clip, m_update;

   always #5 clk = ~clk;

   vu_level_tracker_if bus();

   vu_level_tracker #(
      .DECAY_DIV(DIV), .HOLD_TICKS(HOLD), .REL_STEP(REL),
      .PEAK_STEP(PSTEP), .CLIP_LEVEL(CLIPL)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .i_bus(bus)
   );

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Meter model: ticks every DIV enabled cycles, peak held for HOLD ticks then drops
   task automatic model(input bit r, input bit en, input bit sv, input int s);
      int  mag, dec, nl, np, p;
      bit  tick, old_clip;
      if (r) begin
         m_level = 0; m_peak = 0; m_presc = 0; m_mode = M_TRACK;
         m_hold_left = 0; m_clip_left = 0; m_clip = 0; m_update = 0;
         return;
      end
      if (!en) return;
      tick    = (m_presc == DIV - 1);
      m_presc = tick ? 0 : m_presc + 1;
      mag = (s >= 128) ? 2 * (s - 128) : 2 * (127 - s);
      dec = tick ? ((m_level - REL > 0) ? m_level - REL : 0) : m_level;
      nl  = (sv && mag > dec) ? mag : dec;
      np  = m_peak;
      if (nl > m_peak) begin
         np = nl; m_mode = M_HOLD; m_hold_left = HOLD;
      end else if (m_mode == M_TRACK) begin
         np = nl;
      end else if (m_mode == M_HOLD) begin
         if (tick) begin
            m_hold_left--;
            if (m_hold_left == 0) m_mode = M_FALL;
         end
      end else if (tick) begin
         p = (m_peak - PSTEP > 0) ? m_peak - PSTEP : 0;
         if (p <= nl) begin
            np = nl; m_mode = M_TRACK;
         end else begin
            np = p;
         end
      end
      old_clip = m_clip;
      if (sv && mag >= CLIPL) m_clip_left = HOLD;
      else if (tick && m_clip_left > 0) m_clip_left--;
      m_clip   = (m_clip_left != 0);
      m_update = (nl != m_level) || (np != m_peak) || (m_clip != old_clip);
      m_level  = nl;
      m_peak   = np;
   endtask

   task automatic step(input bit r, input bit en, input bit sv, input int s);
      rst = r;
      bus.enable = en;
      bus.sample_valid = sv;
      bus.sample_in = 8'(s);
      @(posedge clk);
      model(r, en, sv, s);
      if (m_update) sb_q.push_back('{m_level, m_peak, m_clip});
      started = 1'b1;
      #1;
      chk("update_pulse", int'(bus.update), int'(m_update));
   endtask

   task automatic idle();
      step(1'b0, 1'b1, 1'b0, 128);
   endtask

   task automatic to_tick_cycle();
      for (int k = 0; k < DIV && m_presc != DIV - 1; k++) idle();
   endtask

   // Scoreboard monitor: each update pulse must match the oldest expected meter state
   always @(negedge clk) begin
      if (bus.update === 1'b1) begin
         tests++;
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: update with level=%0d peak=%0d clip=%0d, expected no update",
                     bus.level, bus.peak, bus.clip);
         end else begin
            e = sb_q.pop_front();
            if (bus.level !== 8'(e.level) || bus.peak !== 8'(e.peak) || bus.clip !== e.clip) begin
               fails++;
               $display("FAIL sb_state: got level=%0d peak=%0d clip=%0d, expected level=%0d peak=%0d clip=%0d",
                        bus.level, bus.peak, bus.clip, e.level, e.peak, e.clip);
            end
         end
      end
   end

   // Peak marker must never sit below the level
   always @(negedge clk) begin
      if (started) begin
         tests++;
         assert (bus.peak >= bus.level)
         else begin
            fails++;
            $display("FAIL invariant: peak=%0d below level=%0d", bus.peak, bus.level);
         end
      end
   end

   initial begin
      int r, en, sv, s, dis_left, density;
      // reset state
      step(1'b1, 1'b1, 1'b1, 255);
      step(1'b1, 1'b0, 1'b0, 0);
      chk("rst_level", bus.level, 0);
      chk("rst_peak", bus.peak, 0);
      chk("rst_clip", bus.clip, 0);
      // attack, hold, fall, rejoin track
      step(1'b0, 1'b1, 1'b1, 8'hC0);
      chk("t1_level", bus.level, 128);
      chk("t1_peak", bus.peak, 128);
      for (int k = 1; k <= 27; k++) begin
         idle();
         if (k == 3)  chk("t1_decay", bus.level, 127);
         if (k == 11) chk("t2_hold_peak", bus.peak, 128);
         if (k == 15) begin chk("t2_fall1_peak", bus.peak, 126); chk("t2_fall1_level", bus.level, 124); end
         if (k == 19) begin chk("t2_fall2_peak", bus.peak, 124); chk("t2_fall2_level", bus.level, 123); end
         if (k == 23) begin chk("t2_meet_peak", bus.peak, 122); chk("t2_meet_level", bus.level, 122); end
         if (k == 27) chk("t2_track_peak", bus.peak, 121);
      end
      // full-scale sample, decay-then-compare on tick, clip timeout
      step(1'b1, 1'b1, 1'b0, 128);
      to_tick_cycle();
      step(1'b0, 1'b1, 1'b1, 8'hFF);
      chk("t3_level", bus.level, 254);
      chk("t3_clip", bus.clip, 1);
      repeat (DIV) idle();
      chk("t4_level253", bus.level, 253);
      to_tick_cycle();
      step(1'b0, 1'b1, 1'b1, 8'h00);
      chk("t4_tick_attack", bus.level, 254);
      for (int k = 1; k <= 3 * DIV; k++) begin
         idle();
         if (k == 3 * DIV - 1) chk("t3_clip_held", bus.clip, 1);
         if (k == 3 * DIV)     chk("t3_clip_off", bus.clip, 0);
      end
      // smaller sample does not pull the level
      step(1'b1, 1'b1, 1'b0, 128);
      step(1'b0, 1'b1, 1'b1, 8'hB2);
      step(1'b0, 1'b1, 1'b1, 8'hA0);
      chk("t4_small_sample", bus.level, 100);
      // freeze with enable low, prescaler resumes
      step(1'b1, 1'b1, 1'b0, 128);
      step(1'b0, 1'b1, 1'b1, 8'hC0);
      idle();
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 1'b0, 1'b1, 8'hFF);
         chk("t5_frz_level", bus.level, 128);
         chk("t5_frz_peak", bus.peak, 128);
         chk("t5_frz_clip", bus.clip, 0);
      end
      idle();
      chk("t5_resume_pre", bus.level, 128);
      idle();
      chk("t5_resume_tick", bus.level, 127);
      // reset from FALL with clip lit
      step(1'b1, 1'b1, 1'b0, 128);
      step(1'b0, 1'b1, 1'b1, 8'hFF);
      repeat (15) idle();
      step(1'b0, 1'b1, 1'b1, 8'hF9);
      chk("t6_pre_clip", bus.clip, 1);
      chk("t6_pre_peak", bus.peak, 252);
      chk("t6_pre_level", bus.level, 250);
      step(1'b1, 1'b1, 1'b1, 8'hFF);
      chk("t6_rst_level", bus.level, 0);
      chk("t6_rst_peak", bus.peak, 0);
      chk("t6_rst_clip", bus.clip, 0);
      step(1'b0, 1'b1, 1'b1, 8'hC0);
      idle();
      idle();
      chk("t6_pre_tick", bus.level, 128);
      idle();
      chk("t6_first_tick", bus.level, 127);
      // randomized traffic
      dis_left = 0;
      density = 25;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            case ($urandom_range(0, 2))
               0: density = 2;
               1: density = 25;
               default: density = 60;
            endcase
         end
         r = ($urandom_range(0, 399) == 0) ? 1 : 0;
         if (dis_left > 0) begin
            en = 0;
            dis_left--;
         end else begin
            en = 1;
            if ($urandom_range(0, 99) == 0) dis_left = $urandom_range(1, 12);
         end
         sv = ($urandom_range(0, 99) < density) ? 1 : 0;
         case ($urandom_range(0, 3))
            0: s = $urandom_range(0, 255);
            1: s = $urandom_range(0, 15);
            2: s = $urandom_range(240, 255);
            default: s = $urandom_range(100, 156);
         endcase
         step(r[0], en[0], sv[0], s);
      end
      idle();
      idle();
      chk("sb_drain", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
